// File: rtl/cmp_arbiter.sv
// cmp_arbiter: one shared comparer, NREQ requesters, registered valid/ready result.
// Define CMP_ARB_RR_EN for round-robin; otherwise lowest valid index wins.

package comparer_pkg;
  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_NE  = 3'b001;
  localparam logic [2:0] CMP_LT  = 3'b100;
  localparam logic [2:0] CMP_GE  = 3'b101;
  localparam logic [2:0] CMP_LTU = 3'b110;
  localparam logic [2:0] CMP_GEU = 3'b111;
endpackage

module comparer #(
  parameter int N = 32
) (
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic [2:0]   cmp_type,
  output logic         out
);
  import comparer_pkg::*;

  always_comb begin
    out = 1'b0;
    case (cmp_type)
      CMP_EQ:  out = (in1 == in2);
      CMP_NE:  out = (in1 != in2);
      CMP_LT:  out = ($signed(in1) < $signed(in2));
      CMP_GE:  out = ($signed(in1) >= $signed(in2));
      CMP_LTU: out = (in1 < in2);
      CMP_GEU: out = (in1 >= in2);
      default: out = 1'b0;
    endcase
  end
endmodule

module cmp_arbiter #(
  parameter int N    = 32,
  parameter int NREQ = 2,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [3*NREQ-1:0] req_type,
  input  logic [N*NREQ-1:0] req_in1,
  input  logic [N*NREQ-1:0] req_in2,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic              rsp_out
);
  import comparer_pkg::*;

  logic              free;
  logic              gnt_vld;
  logic              accept;
  logic              cmp_out;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    gnt;
  logic [2*NREQ-1:0] rot;
  logic [2:0]        sel_type;
  logic [N-1:0]      sel_in1;
  logic [N-1:0]      sel_in2;

  assign free   = !rsp_valid || rsp_ready;
  assign accept = gnt_vld && free && rst_n;

  // Rotate so bit 0 is the requester at ptr; first set bit wins.
  assign rot = {req_valid, req_valid} >> ptr;

  always_comb begin : arb
    int k;
    gnt_vld = 1'b0;
    gnt     = '0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_vld && rot[i]) begin
        gnt_vld = 1'b1;
        k       = int'(ptr) + i;
        if (k >= NREQ) k = k - NREQ;
        gnt     = IDW'(k);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = accept && (gnt == IDW'(i));
  end

  always_comb begin : mux
    sel_type = req_type[2:0];
    sel_in1  = req_in1[N-1:0];
    sel_in2  = req_in2[N-1:0];
    for (int i = 1; i < NREQ; i++) begin
      if (gnt == IDW'(i)) begin
        sel_type = req_type[3*i +: 3];
        sel_in1  = req_in1[N*i +: N];
        sel_in2  = req_in2[N*i +: N];
      end
    end
  end

  comparer #(.N(N)) u_cmp (
    .in1      (sel_in1),
    .in2      (sel_in2),
    .cmp_type (sel_type),
    .out      (cmp_out)
  );

`ifdef CMP_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      ptr <= '0;
    else if (accept)
      ptr <= (gnt == IDW'(NREQ-1)) ? '0 : gnt + IDW'(1);
  end
`else
  assign ptr = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_out   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt;
      rsp_out   <= cmp_out;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cmp_arbiter.sv
// tb_cmp_arbiter: directed scenarios plus randomized traffic against
// a spec-level model (cyclic search, result queue of depth one).
module tb_cmp_arbiter;
  import comparer_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
`ifdef CMP_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [3*NREQ-1:0] req_type;
  logic [N*NREQ-1:0] req_in1;
  logic [N*NREQ-1:0] req_in2;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic              rsp_out;

  cmp_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_out   (rsp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit            m_valid = 1'b0;
  int            m_id    = 0;
  bit            m_out   = 1'b0;
  int            m_ptr   = 0;
  logic [NREQ-1:0] e_rdy;
  logic [NREQ-1:0] obs_rdy;

  logic [2:0] types [6] = '{CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};

  function automatic bit ref_cmp(input logic [2:0] t,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (t)
      CMP_EQ:  return ua == ub;
      CMP_NE:  return ua != ub;
      CMP_LT:  return sa < sb;
      CMP_GE:  return sa >= sb;
      CMP_LTU: return ua < ub;
      CMP_GEU: return ua >= ub;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive(input int idx, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] b);
    req_type[3*idx +: 3] = t;
    req_in1[N*idx +: N]  = a;
    req_in2[N*idx +: N]  = b;
  endtask

  task automatic drive_rand();
    for (int i = 0; i < NREQ; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 7);
      drive(i, types[$urandom_range(0, 5)], a, b);
    end
  endtask

  // Sample combinational ready mid-cycle, advance the model, settle after edge.
  task automatic tick();
    bit free;
    int win;
    @(negedge clk);
    free = !m_valid || rsp_ready;
    win  = -1;
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    e_rdy   = (rst_n && free && win >= 0) ? NREQ'(1 << win) : '0;
    obs_rdy = req_ready;
    if (!rst_n) begin
      m_valid = 0; m_id = 0; m_out = 0; m_ptr = 0;
    end else if (free && win >= 0) begin
      m_valid = 1;
      m_id    = win;
      m_out   = ref_cmp(req_type[3*win +: 3], req_in1[N*win +: N],
                        req_in2[N*win +: N]);
      if (RR) m_ptr = (win + 1) % NREQ;
    end else if (m_valid && rsp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; req_valid = 2'b11; rsp_ready = 0;
    drive_rand();
    repeat (2) begin
      tick();
      checks++;
      if (obs_rdy !== 2'b00) begin
        errors++; $display("FAIL reset_rdy got %b exp 00", obs_rdy);
      end
      checks++;
      if (rsp_valid !== 1'b0) begin
        errors++; $display("FAIL reset_valid got %b exp 0", rsp_valid);
      end
    end
    rst_n = 1; req_valid = 2'b01; rsp_ready = 1;
    drive(0, CMP_LT, 32'hFFFF_FFFF, 32'd1);
    tick();
    checks++;
    if (obs_rdy !== 2'b01) begin
      errors++; $display("FAIL first_rdy got %b exp 01", obs_rdy);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_out !== 1'b1 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL first_rsp got v%b o%b id%0d exp v1 o1 id0",
               rsp_valid, rsp_out, rsp_id);
    end
  endtask

  task automatic test_fairness();
    rst_n = 0; req_valid = 0;
    tick();
    rst_n = 1; req_valid = 2'b11; rsp_ready = 1;
    for (int c = 0; c < 4; c++) begin
      int exp;
      exp = RR ? (c % 2) : 0;
      drive_rand();
      tick();
      checks++;
      if (obs_rdy !== NREQ'(1 << exp)) begin
        errors++; $display("FAIL fair_gnt%0d got %b exp grant %0d", c, obs_rdy, exp);
      end
      checks++;
      if (rsp_id !== IDW'(exp) || rsp_out !== m_out) begin
        errors++;
        $display("FAIL fair_rsp%0d got id%0d o%b exp id%0d o%b",
                 c, rsp_id, rsp_out, exp, m_out);
      end
    end
  endtask

  task automatic test_back_pressure();
    req_valid = 2'b10; rsp_ready = 1;
    drive(1, CMP_GEU, 32'd5, 32'd7);
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 1'b0) begin
      errors++;
      $display("FAIL bp_load got v%b id%0d o%b exp v1 id1 o0",
               rsp_valid, rsp_id, rsp_out);
    end
    rsp_ready = 0; req_valid = 2'b11;
    repeat (3) begin
      drive_rand();
      tick();
      checks++;
      if (obs_rdy !== 2'b00) begin
        errors++; $display("FAIL bp_rdy got %b exp 00", obs_rdy);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold got v%b id%0d o%b exp v1 id1 o0",
                 rsp_valid, rsp_id, rsp_out);
      end
    end
    rsp_ready = 1; req_valid = 2'b01;
    drive(0, CMP_EQ, 32'd9, 32'd9);
    tick();
    checks++;
    if (obs_rdy !== 2'b01) begin
      errors++; $display("FAIL bp_release_rdy got %b exp 01", obs_rdy);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_out !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got v%b id%0d o%b exp v1 id0 o1",
               rsp_valid, rsp_id, rsp_out);
    end
  endtask

  task automatic test_back_to_back();
    req_valid = 2'b01; rsp_ready = 1;
    drive(0, CMP_LTU, 32'h8000_0000, 32'd0);
    tick();
    checks++;
    if (obs_rdy !== 2'b01 || rsp_valid !== 1'b1 || rsp_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ltu got rdy%b v%b o%b exp rdy01 v1 o0",
               obs_rdy, rsp_valid, rsp_out);
    end
    drive(0, CMP_LT, 32'h8000_0000, 32'd0);
    tick();
    checks++;
    if (obs_rdy !== 2'b01 || rsp_valid !== 1'b1 || rsp_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_lt got rdy%b v%b o%b exp rdy01 v1 o1",
               obs_rdy, rsp_valid, rsp_out);
    end
  endtask

  task automatic test_withdrawn();
    int exp;
    req_valid = 2'b01; rsp_ready = 1;
    drive(0, CMP_NE, 32'd1, 32'd2);
    tick();
    rsp_ready = 0; req_valid = 2'b10;
    drive(1, CMP_EQ, 32'd3, 32'd3);
    repeat (2) begin
      tick();
      checks++;
      if (obs_rdy !== 2'b00 || rsp_id !== 1'b0) begin
        errors++;
        $display("FAIL wd_stall got rdy%b id%0d exp rdy00 id0", obs_rdy, rsp_id);
      end
    end
    req_valid = 2'b00; rsp_ready = 1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL wd_drop got v%b id%0d exp v0 id0", rsp_valid, rsp_id);
    end
    exp = RR ? 1 : 0;
    req_valid = 2'b11;
    drive_rand();
    tick();
    checks++;
    if (obs_rdy !== NREQ'(1 << exp)) begin
      errors++; $display("FAIL wd_ptr got %b exp grant %0d", obs_rdy, exp);
    end
  endtask

  task automatic test_reset_mid_stall();
    req_valid = 2'b10; rsp_ready = 1;
    drive(1, CMP_GE, 32'd3, 32'd3);
    tick();
    rsp_ready = 0; req_valid = 2'b00;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_out !== 1'b1) begin
      errors++;
      $display("FAIL rms_pend got v%b id%0d o%b exp v1 id1 o1",
               rsp_valid, rsp_id, rsp_out);
    end
    rst_n = 0; req_valid = 2'b11;
    tick();
    checks++;
    if (obs_rdy !== 2'b00) begin
      errors++; $display("FAIL rms_rdy got %b exp 00", obs_rdy);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_out !== 1'b0) begin
      errors++;
      $display("FAIL rms_clr got v%b id%0d o%b exp v0 id0 o0",
               rsp_valid, rsp_id, rsp_out);
    end
    rst_n = 1; rsp_ready = 1;
    drive_rand();
    tick();
    checks++;
    if (obs_rdy !== 2'b01 || rsp_id !== 1'b0) begin
      errors++;
      $display("FAIL rms_restart got rdy%b id%0d exp rdy01 id0", obs_rdy, rsp_id);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      drive_rand();
      tick();
      checks++;
      if (obs_rdy !== e_rdy) begin
        errors++; $display("FAIL rnd_rdy c%0d got %b exp %b", c, obs_rdy, e_rdy);
      end
      checks++;
      if (rsp_valid !== m_valid) begin
        errors++; $display("FAIL rnd_valid c%0d got %b exp %b", c, rsp_valid, m_valid);
      end
      checks++;
      if (rsp_id !== IDW'(m_id)) begin
        errors++; $display("FAIL rnd_id c%0d got %0d exp %0d", c, rsp_id, m_id);
      end
      checks++;
      if (rsp_out !== m_out) begin
        errors++; $display("FAIL rnd_out c%0d got %b exp %b", c, rsp_out, m_out);
      end
    end
  endtask

  initial begin
    rst_n = 0; req_valid = 0; rsp_ready = 0;
    req_type = '0; req_in1 = '0; req_in2 = '0;
    test_reset();
    test_fairness();
    test_back_pressure();
    test_back_to_back();
    test_withdrawn();
    test_reset_mid_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
